vx_ahb_sram_sub: RTL and testbench

VX_AHB_SRAM_SUB -- requirements
Module: vx_ahb_sram_sub

---
 rtl/vx_ahb_pkg.sv | 27 ++
 rtl/vx_ahb_sram_sub_if.sv | 29 ++
 rtl/vx_ahb_sram_sub_bank.sv | 32 +++
 rtl/vx_ahb_sram_sub.sv | 143 ++++++++++++++
 tb/tb_vx_ahb_sram_sub.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/vx_ahb_pkg.sv
`default_nettype none
// ============================================================================
// vx_ahb_pkg : shared AHB encodings and subordinate FSM state type
// Rev 1.0
// ============================================================================
package vx_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic       HRESP_OKAY  = 1'b0;
    localparam logic       HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } ahb_sub_state_t;

endpackage : vx_ahb_pkg
`default_nettype wire

// File: rtl/vx_ahb_sram_sub_if.sv
`default_nettype none
// ============================================================================
// ahb_if : AHB-lite bundle between a manager and one subordinate
// Rev 1.0
// ============================================================================
interface ahb_if;
    logic        HSEL;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [3:0]  HWSTRB;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HTRANS, HWRITE, HSIZE, HADDR, HWDATA, HWSTRB, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport subordinate (
        input  HSEL, HTRANS, HWRITE, HSIZE, HADDR, HWDATA, HWSTRB, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface : ahb_if
`default_nettype wire

// File: rtl/vx_ahb_sram_sub_bank.sv
`default_nettype none
// ============================================================================
// vx_ahb_sram_bank : 32-bit word array, byte-enabled sync write, async read
// Rev 1.0
// ============================================================================
module vx_ahb_sram_bank #(
    parameter int unsigned WORDS = 1024
) (
    input  wire logic                     clk,
    input  wire logic                     we,
    input  wire logic [$clog2(WORDS)-1:0] waddr,
    input  wire logic [3:0]               wstrb,
    input  wire logic [31:0]              wdata,
    input  wire logic [$clog2(WORDS)-1:0] raddr,
    output logic      [31:0]              rdata
);

    // One array per byte lane keeps each strobe a plain per-lane write enable.
    for (genvar b = 0; b < 4; b++) begin : g_lane
        logic [7:0] r_mem [WORDS];

        always_ff @(posedge clk) begin
            if (we && wstrb[b]) begin
                r_mem[waddr] <= wdata[8*b +: 8];
            end
        end

        assign rdata[8*b +: 8] = r_mem[raddr];
    end

endmodule : vx_ahb_sram_bank
`default_nettype wire

// File: rtl/vx_ahb_sram_sub.sv
`default_nettype none
// ============================================================================
// vx_ahb_sram_sub : AHB-lite SRAM subordinate with optional wait states
// Build option: VX_AHB_SRAM_WAIT_EN enables WAIT_STATES (else zero-wait).
// Rev 1.0
// ============================================================================
module vx_ahb_sram_sub
    import vx_ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input  wire logic  clk,
    input  wire logic  nRST,
    ahb_if.subordinate ahb
);

    localparam int unsigned AW   = $clog2(MEM_WORDS);
    localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;

    ahb_sub_state_t r_state;
    ahb_sub_state_t w_state_nxt;
    logic           r_valid;
    logic           w_valid_nxt;
    logic           r_write;
    logic [AW-1:0]  r_idx;
    logic [3:0]     r_strb;

    logic [32:0]    w_diff;
    logic           w_err;
    logic           w_accept;
    logic           w_open;
    logic           w_take;
    logic           w_final;
    logic           w_wait_last;
    logic [31:0]    w_rdata;

    // 33-bit difference: addresses below BASE_ADDR wrap above SPAN.
    assign w_diff   = {1'b0, ahb.HADDR} - {1'b0, BASE_ADDR};
    assign w_err    = (w_diff >= SPAN) ||
                      (ahb.HADDR[1:0] != 2'b00) ||
                      (ahb.HSIZE != HSIZE_WORD);
    assign w_accept = ahb.HSEL && ahb.HREADY &&
                      ((ahb.HTRANS == HTRANS_NONSEQ) || (ahb.HTRANS == HTRANS_SEQ));
    assign w_open   = (r_state == ST_IDLE) || (r_state == ST_ERR2);
    assign w_take   = w_accept && w_open;

`ifdef VX_AHB_SRAM_WAIT_EN
    localparam int unsigned CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_cnt <= '0;
        end else if (w_take && !w_err) begin
            r_cnt <= CW'(WAIT_STATES);
        end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign w_wait_last = (r_cnt == CW'(1));
`else
    assign w_wait_last = 1'b1;
`endif

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_strb  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            if (w_take) begin
                r_write <= ahb.HWRITE;
                r_idx   <= w_diff[AW+1:2];
                r_strb  <= ahb.HWSTRB;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        unique case (r_state)
            ST_IDLE, ST_ERR2: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
                if (w_take) begin
                    if (w_err) begin
                        w_state_nxt = ST_ERR1;
                    end else begin
                        w_valid_nxt = 1'b1;
`ifdef VX_AHB_SRAM_WAIT_EN
                        if (WAIT_STATES != 0) begin
                            w_state_nxt = ST_WAIT;
                        end
`endif
                    end
                end
            end
            // The final (HREADYOUT=1) cycle of a waited transfer runs in IDLE.
            ST_WAIT: begin
                if (w_wait_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ERR1: begin
                w_state_nxt = ST_ERR2;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    assign w_final = (r_state == ST_IDLE) && r_valid;

    vx_ahb_sram_bank #(
        .WORDS (MEM_WORDS)
    ) u_bank (
        .clk   (clk),
        .we    (w_final && r_write),
        .waddr (r_idx),
        .wstrb (r_strb),
        .wdata (ahb.HWDATA),
        .raddr (r_idx),
        .rdata (w_rdata)
    );

    assign ahb.HREADYOUT = !((r_state == ST_WAIT) || (r_state == ST_ERR1));
    assign ahb.HRESP     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR
                                                                           : HRESP_OKAY;
    assign ahb.HRDATA    = (w_final && !r_write) ? w_rdata : 32'h0;

endmodule : vx_ahb_sram_sub
`default_nettype wire

// File: tb/tb_vx_ahb_sram_sub.sv
`default_nettype none
// ============================================================================
// tb_vx_ahb_sram_sub : directed self-checking bench for vx_ahb_sram_sub
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_vx_ahb_sram_sub;
    import vx_ahb_pkg::*;

`ifdef VX_AHB_SRAM_WAIT_EN
    localparam int WS = 2;
`else
    localparam int WS = 0;
`endif

    logic clk  = 1'b0;
    logic nRST = 1'b0;

    ahb_if ahb ();
    assign ahb.HREADY = ahb.HREADYOUT;

    vx_ahb_sram_sub #(
        .BASE_ADDR   (32'h0000_0000),
        .MEM_WORDS   (1024),
        .WAIT_STATES (2)
    ) dut (
        .clk  (clk),
        .nRST (nRST),
        .ahb  (ahb)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic        p_wr    [32];
    logic [31:0] p_addr  [32];
    logic [31:0] p_wdata [32];
    logic [31:0] p_rdata [32];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        ahb.HSEL   = 1'b0;
        ahb.HTRANS = HTRANS_IDLE;
        ahb.HWRITE = 1'b0;
        ahb.HSIZE  = HSIZE_WORD;
        ahb.HADDR  = 32'h0;
        ahb.HWDATA = 32'h0;
        ahb.HWSTRB = 4'h0;
    endtask

    // Single non-pipelined transfer; caller sits just after a rising edge.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input logic [3:0] strb, input logic [1:0] trans,
                        output logic [31:0] rdata, output int lows,
                        output logic lo_resp, output logic fin_resp);
        ahb.HSEL   = 1'b1;
        ahb.HTRANS = trans;
        ahb.HWRITE = wr;
        ahb.HSIZE  = size;
        ahb.HADDR  = addr;
        ahb.HWSTRB = strb;
        @(posedge clk); #1;
        bus_idle();
        ahb.HWDATA = wdata;
        lows = 0; lo_resp = 1'b0; fin_resp = 1'b0; rdata = 32'h0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ahb.HREADYOUT) begin
                rdata    = ahb.HRDATA;
                fin_resp = ahb.HRESP;
                break;
            end
            lows++;
            lo_resp |= ahb.HRESP;
        end
        @(posedge clk); #1;
    endtask

    task automatic drive_ap(input int i);
        ahb.HSEL   = 1'b1;
        ahb.HTRANS = (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
        ahb.HWRITE = p_wr[i];
        ahb.HSIZE  = HSIZE_WORD;
        ahb.HADDR  = p_addr[i];
        ahb.HWSTRB = 4'hF;
    endtask

    // Pipelined stream of n transfers from the p_* tables.
    task automatic run_pipe(input int n, output int cycles, output int lows, output logic resp_any);
        int   ap, dp, nxt, done;
        logic rdy;
        ap = 0; dp = -1; nxt = 1; done = 0;
        cycles = 0; lows = 0; resp_any = 1'b0;
        drive_ap(0);
        while (done < n && cycles < 400) begin
            @(negedge clk);
            rdy = ahb.HREADYOUT;
            resp_any |= ahb.HRESP;
            if (!rdy) lows++;
            else if (dp >= 0 && !p_wr[dp]) p_rdata[dp] = ahb.HRDATA;
            @(posedge clk); #1;
            cycles++;
            if (rdy) begin
                if (dp >= 0) done++;
                dp = ap;
                if (nxt < n) begin
                    drive_ap(nxt);
                    ap = nxt;
                    nxt++;
                end else begin
                    ap = -1;
                    ahb.HSEL   = 1'b0;
                    ahb.HTRANS = HTRANS_IDLE;
                end
                ahb.HWDATA = (dp >= 0) ? p_wdata[dp] : 32'h0;
            end
        end
        bus_idle();
    endtask

    logic [31:0] rd;
    int          lows, cyc;
    logic        lo_r, fin_r, r_any;

    initial begin
        bus_idle();
        #2;
        check_eq("rst_hreadyout", 32'(ahb.HREADYOUT), 32'd1);
        check_eq("rst_hresp",     32'(ahb.HRESP),     32'd0);
        check_eq("rst_hrdata",    ahb.HRDATA,         32'h0);
        repeat (3) @(posedge clk);
        #1 nRST = 1'b1;
        @(posedge clk); #1;

        // Full-word write then read
        xfer(1'b1, 32'h10, HSIZE_WORD, 32'hDEAD_BEEF, 4'hF, HTRANS_NONSEQ, rd, lows, lo_r, fin_r);
        check_eq("wr10_lows", 32'(lows), 32'(WS));
        check_eq("wr10_resp", 32'({lo_r, fin_r}), 32'd0);
        xfer(1'b0, 32'h10, HSIZE_WORD, 32'h0, 4'hF, HTRANS_NONSEQ, rd, lows, lo_r, fin_r);
        check_eq("rd10_lows", 32'(lows), 32'(WS));
        check_eq("rd10_resp", 32'({lo_r, fin_r}), 32'd0);
        check_eq("rd10_data", rd, 32'hDEAD_BEEF);

        // Partial write over all-ones
        xfer(1'b1, 32'h20, HSIZE_WORD, 32'hFFFF_FFFF, 4'hF, HTRANS_NONSEQ, rd, lows, lo_r, fin_r);
        xfer(1'b1, 32'h20, HSIZE_WORD, 32'h1122_3344, 4'b0101, HTRANS_NONSEQ, rd, lows, lo_r, fin_r);
        xfer(1'b0, 32'h20, HSIZE_WORD, 32'h0, 4'hF, HTRANS_NONSEQ, rd, lows, lo_r, fin_r);
        check_eq("partial_data", rd, 32'hFF22_FF44);

        // Out-of-range read: first word past the array
        xfer(1'b0, 32'h1000, HSIZE_WORD, 32'h0, 4'hF, HTRANS_NONSEQ, rd, lows, lo_r, fin_r);
        check_eq("oor_lows",     32'(lows),  32'd1);
        check_eq("oor_err1",     32'(lo_r),  32'd1);
        check_eq("oor_err2",     32'(fin_r), 32'd1);
        check_eq("oor_hrdata",   rd,         32'h0);
        // Last valid word is fine
        xfer(1'b0, 32'hFFC, HSIZE_WORD, 32'h0, 4'hF, HTRANS_NONSEQ, rd, lows, lo_r, fin_r);
        check_eq("last_word_resp", 32'({lo_r, fin_r}), 32'd0);

        // Misaligned and wrong-size writes must not touch the array
        xfer(1'b1, 32'h22, HSIZE_WORD, 32'h0, 4'hF, HTRANS_NONSEQ, rd, lows, lo_r, fin_r);
        check_eq("misal_resp", 32'({lows[1:0], lo_r, fin_r}), 32'b0111);
        xfer(1'b1, 32'h20, 3'b001, 32'h0, 4'hF, HTRANS_NONSEQ, rd, lows, lo_r, fin_r);
        check_eq("size_resp",  32'({lows[1:0], lo_r, fin_r}), 32'b0111);
        // IDLE/BUSY and deselected phases are ignored
        xfer(1'b1, 32'h20, HSIZE_WORD, 32'h0, 4'hF, HTRANS_BUSY, rd, lows, lo_r, fin_r);
        check_eq("busy_resp",  32'({lows[1:0], lo_r, fin_r}), 32'b0000);
        xfer(1'b0, 32'h20, HSIZE_WORD, 32'h0, 4'hF, HTRANS_NONSEQ, rd, lows, lo_r, fin_r);
        check_eq("err_unchanged", rd, 32'hFF22_FF44);

        // Back-to-back write stream then read stream
        for (int i = 0; i < 16; i++) begin
            p_wr[i]    = 1'b1;
            p_addr[i]  = 32'(4 * i);
            p_wdata[i] = 32'hC0DE_0000 + 32'(i) * 32'h0000_1001;
        end
        run_pipe(16, cyc, lows, r_any);
        check_eq("stream_cycles", 32'(cyc),   32'(16 * (WS + 1) + 1));
        check_eq("stream_lows",   32'(lows),  32'(16 * WS));
        check_eq("stream_resp",   32'(r_any), 32'd0);
        for (int i = 0; i < 16; i++) begin
            p_wr[i]    = 1'b0;
            p_rdata[i] = 32'hxxxx_xxxx;
        end
        run_pipe(16, cyc, lows, r_any);
        check_eq("rdstream_cycles", 32'(cyc), 32'(16 * (WS + 1) + 1));
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("rdstream_%0d", i), p_rdata[i], 32'hC0DE_0000 + 32'(i) * 32'h0000_1001);
        end

        // Write immediately followed by read of the same word
        p_wr[0] = 1'b1; p_addr[0] = 32'h80; p_wdata[0] = 32'hCAFE_F00D;
        p_wr[1] = 1'b0; p_addr[1] = 32'h80; p_wdata[1] = 32'h0;
        run_pipe(2, cyc, lows, r_any);
        check_eq("b2b_rdata", p_rdata[1], 32'hCAFE_F00D);

        // Reset during the first data-phase cycle of a write
        xfer(1'b1, 32'h40, HSIZE_WORD, 32'h1234_5678, 4'hF, HTRANS_NONSEQ, rd, lows, lo_r, fin_r);
        ahb.HSEL = 1'b1; ahb.HTRANS = HTRANS_NONSEQ; ahb.HWRITE = 1'b1;
        ahb.HSIZE = HSIZE_WORD; ahb.HADDR = 32'h40; ahb.HWSTRB = 4'hF;
        @(posedge clk); #1;
        bus_idle();
        ahb.HWDATA = 32'hA5A5_A5A5;
        nRST = 1'b0;
        #1;
        check_eq("rstmid_hready", 32'(ahb.HREADYOUT), 32'd1);
        check_eq("rstmid_hresp",  32'(ahb.HRESP),     32'd0);
        @(posedge clk); #1;
        nRST = 1'b1;
        @(posedge clk); #1;
        xfer(1'b0, 32'h40, HSIZE_WORD, 32'h0, 4'hF, HTRANS_NONSEQ, rd, lows, lo_r, fin_r);
        check_eq("rstmid_old", rd, 32'h1234_5678);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_vx_ahb_sram_sub
`default_nettype wire
